// File: rtl/mips_defs.sv
// Shared MIPS constants: fetch address map, exception codes and the fetch FSM state type.
package mips_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6ffc;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_addr_check.sv
// Combinational word-alignment and window check on an address; shared by fetch and data-side checkers.
module pc_addr_check
  import mips_defs::*;
#(
  parameter logic [31:0] LO       = IM_LO,
  parameter logic [31:0] HI       = IM_HI,
  parameter logic [4:0]  FAULT_CODE = EXC_ADEL
) (
  input  logic [31:0] i_addr,
  output logic [4:0]  o_exc_code
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (i_addr[1:0] != 2'b00);
  assign w_out_of_range = (i_addr < LO) || (i_addr > HI);
  assign o_exc_code     = (w_misaligned || w_out_of_range) ? FAULT_CODE : EXC_INT;

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural fetch PC: arbitrates exception entry, eret, stall and sequencing;
// squashes F for one cycle after a redirect and counts accepted fetches.
//
// state | meaning
// RUN   | normal fetch, F/D loads the fetched instruction
// FLUSH | cycle after exception/eret redirect; F/D loads a bubble
module fetch_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] P_RESET_PC   = RESET_PC,
  parameter logic [31:0] P_HANDLER_PC = HANDLER_PC,
  parameter logic [31:0] P_IM_LO      = IM_LO,
  parameter logic [31:0] P_IM_HI      = IM_HI
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_npc_in,
  input  logic        i_npc_redirect,
  input  logic        i_branch_d,
  input  logic        i_stall,
  input  logic        i_exc_req,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  output logic [31:0] o_pc,
  output logic [4:0]  o_exc_code,
  output logic        o_bd,
  output logic        o_flush_f,
  output logic [31:0] o_fetch_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic         r_bd;
  logic [31:0]  r_fetch_cnt;
  logic         w_redirect;
  logic         w_advance;
  logic         w_count;

  assign w_redirect = i_exc_req || i_eret;
  assign w_advance  = !w_redirect && !i_stall;
  // the bubble cycle loads a new pc but is not an accepted fetch
  assign w_count    = w_advance && (r_state == RUN);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN:     if (w_redirect) w_state_nxt = FLUSH;
      FLUSH:   if (w_redirect) w_state_nxt = FLUSH;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= P_RESET_PC;
      r_bd        <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      if (i_exc_req) begin
        r_pc <= P_HANDLER_PC;
        r_bd <= 1'b0;
      end else if (i_eret) begin
        r_pc <= i_epc;
        r_bd <= 1'b0;
      end else if (w_advance) begin
        r_pc <= i_npc_in;
        r_bd <= i_branch_d;
      end
      if (w_count) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  pc_addr_check #(
    .LO         (P_IM_LO),
    .HI         (P_IM_HI),
    .FAULT_CODE (EXC_ADEL)
  ) u_pc_addr_check (
    .i_addr     (r_pc),
    .o_exc_code (o_exc_code)
  );

  assign o_pc        = r_pc;
  assign o_bd        = r_bd;
  assign o_flush_f   = (r_state == FLUSH);
  assign o_fetch_cnt = r_fetch_cnt;

  // a non-redirecting NPC must present plain sequential pc+4
  a_npc_sequential : assert property (@(posedge i_clk) disable iff (i_reset)
    (!i_npc_redirect && !i_stall && !i_exc_req && !i_eret) |-> (i_npc_in == r_pc + 32'd4));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random stimulus vs a cycle model.
module tb_fetch_pc_unit;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_HANDLER  = 32'h0000_4180;
  localparam logic [31:0] T_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] T_IM_HI    = 32'h0000_6ffc;

  logic        clk;
  logic        reset;
  logic [31:0] npc_in;
  logic        npc_redirect;
  logic        branch_d;
  logic        stall;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [4:0]  exc_code;
  logic        bd;
  logic        flush_f;
  logic [31:0] fetch_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_flush;
  logic [31:0] m_cnt;

  fetch_pc_unit dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_npc_in       (npc_in),
    .i_npc_redirect (npc_redirect),
    .i_branch_d     (branch_d),
    .i_stall        (stall),
    .i_exc_req      (exc_req),
    .i_eret         (eret),
    .i_epc          (epc),
    .o_pc           (pc),
    .o_exc_code     (exc_code),
    .o_bd           (bd),
    .o_flush_f      (flush_f),
    .o_fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_exc(input logic [31:0] a);
    if (a % 4 != 0 || a < T_IM_LO || a > T_IM_HI) return 32'd4;
    return 32'd0;
  endfunction

  // One clock: apply inputs, advance the model by the architectural rules, compare all outputs.
  task automatic step(input logic rst, input logic [31:0] npc, input logic redir,
                      input logic br, input logic stl, input logic exc,
                      input logic ert, input logic [31:0] e_pc);
    reset = rst; npc_in = npc; npc_redirect = redir; branch_d = br;
    stall = stl; exc_req = exc; eret = ert; epc = e_pc;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = T_RESET_PC; m_bd = 1'b0; m_flush = 1'b0; m_cnt = 32'd0;
    end else begin
      if (!exc && !ert && !stl && !m_flush) m_cnt = m_cnt + 1;
      if (exc)       begin m_pc = T_HANDLER; m_bd = 1'b0; end
      else if (ert)  begin m_pc = e_pc;      m_bd = 1'b0; end
      else if (!stl) begin m_pc = npc;       m_bd = br;   end
      m_flush = exc || ert;
    end
    chk("pc", pc, m_pc);
    chk("exc_code", {27'd0, exc_code}, exp_exc(m_pc));
    chk("bd", {31'd0, bd}, {31'd0, m_bd});
    chk("flush_f", {31'd0, flush_f}, {31'd0, m_flush});
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic seq(input logic br);
    step(1'b0, m_pc + 32'd4, 1'b0, br, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    step(1'b0, tgt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    m_pc = 32'd0; m_bd = 1'b0; m_flush = 1'b0; m_cnt = 32'd0;
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5000);
    step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset_pc", pc, 32'h3000);

    seq(1'b0); seq(1'b0); seq(1'b0);
    chk("seq_pc", pc, 32'h300c);
    chk("seq_cnt", fetch_cnt, 32'd3);

    seq(1'b0);
    chk("pre_branch_pc", pc, 32'h3010);
    seq(1'b1);
    chk("ds_pc", pc, 32'h3014);
    chk("ds_bd", {31'd0, bd}, 32'd1);
    jump(32'h3040);
    chk("tgt_pc", pc, 32'h3040);
    chk("tgt_bd", {31'd0, bd}, 32'd0);

    jump(32'h3020);
    step(1'b0, 32'h3024, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h3024, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("stall_pc", pc, 32'h3020);
    seq(1'b0);
    chk("unstall_pc", pc, 32'h3024);

    jump(32'h3100);
    step(1'b0, 32'h3104, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("exc_pc", pc, 32'h4180);
    chk("exc_flush", {31'd0, flush_f}, 32'd1);
    seq(1'b0);
    chk("exc_flush_drop", {31'd0, flush_f}, 32'd0);
    seq(1'b0);
    step(1'b0, 32'h5555_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3104);
    chk("eret_pc", pc, 32'h3104);
    chk("eret_flush", {31'd0, flush_f}, 32'd1);
    seq(1'b0);

    jump(32'h3002);
    chk("adel_misalign", {27'd0, exc_code}, 32'd4);
    jump(32'h7000);
    chk("adel_high", {27'd0, exc_code}, 32'd4);
    jump(32'h6ffc);
    chk("top_legal", {27'd0, exc_code}, 32'd0);
    jump(32'h2ffc);
    chk("adel_low", {27'd0, exc_code}, 32'd4);

    step(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("reflush", {31'd0, flush_f}, 32'd1);
    step(1'b1, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_flush_pc", pc, 32'h3000);
    chk("rst_flush_f", {31'd0, flush_f}, 32'd0);
    chk("rst_flush_cnt", fetch_cnt, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_br, r_stl, r_exc, r_ert, r_redir;
      logic [31:0] r_npc, r_epc;
      int          sel;
      r_rst = ($urandom_range(0, 99) < 2);
      r_br  = 1'($urandom_range(0, 1));
      r_stl = ($urandom_range(0, 99) < 20);
      r_exc = ($urandom_range(0, 99) < 6);
      r_ert = ($urandom_range(0, 99) < 6);
      r_epc = {18'd0, 14'($urandom_range(16'h2ff0 >> 2, 16'h7010 >> 2)), 2'b00};
      sel   = $urandom_range(0, 9);
      if (sel < 6) begin
        r_npc = m_pc + 32'd4; r_redir = 1'b0;
      end else if (sel < 9) begin
        r_npc = {18'd0, 14'($urandom_range(16'h2ff0 >> 2, 16'h7010 >> 2)), 2'b00};
        r_redir = 1'b1;
      end else begin
        r_npc = $urandom; r_redir = 1'b1;
      end
      step(r_rst, r_npc, r_redir, r_br, r_stl, r_exc, r_ert, r_epc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
